// File: rtl/wb_retire_ctrl.sv
// wb_retire_ctrl: write-back register, register-file write port, pending-write scoreboard and retired-instruction counter.
module wb_retire_ctrl #(
  parameter int SB_W  = 2,
  parameter int CNT_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             M_valid_i,
  input  logic [6:0]       M_opcode_i,
  input  logic [4:0]       M_rd_i,
  input  logic [31:0]      M_valE_i,
  input  logic [31:0]      m_valM_i,
  input  logic [31:0]      M_default_pc_i,
  input  logic             stall_i,
  input  logic             iss_valid_i,
  input  logic [6:0]       iss_opcode_i,
  input  logic [4:0]       iss_rd_i,
  input  logic             kill_valid_i,
  input  logic [4:0]       kill_rd_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  output logic [6:0]       W_opcode_o,
  output logic [4:0]       W_rd_o,
  output logic [31:0]      W_valE_o,
  output logic [31:0]      W_valM_o,
  output logic [31:0]      W_default_pc_o,
  output logic             w_en_o,
  output logic [4:0]       w_rd_o,
  output logic [31:0]      w_data_o,
  output logic             pend_rs1_o,
  output logic             pend_rs2_o,
  output logic             sb_err_o,
  output logic [CNT_W-1:0] instret_o
);
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [SB_W+1:0] MAX = (SB_W+2)'((1 << SB_W) - 1);

  function automatic logic is_wr(input logic [6:0] op, input logic [4:0] rd);
    return (rd != 5'd0) && (op == OP_LOAD || op == OP_JAL || op == OP_JALR || op == OP_R ||
                            op == OP_IMM || op == OP_LUI || op == OP_AUIPC);
  endfunction

  logic            w_valid, retire, err;
  logic [SB_W-1:0] cnt [0:31];
  logic [SB_W-1:0] cnt_nxt [0:31];
  logic [SB_W+1:0] v, s, dec;

  assign retire     = w_valid & ~stall_i;
  assign w_en_o     = retire & is_wr(W_opcode_o, W_rd_o);
  assign w_rd_o     = W_rd_o;
  assign w_data_o   = W_opcode_o == OP_LOAD ? W_valM_o :
                      (W_opcode_o == OP_JAL || W_opcode_o == OP_JALR) ? W_default_pc_o : W_valE_o;
  assign pend_rs1_o = (rs1_i != 5'd0) && (cnt[rs1_i] != '0);
  assign pend_rs2_o = (rs2_i != 5'd0) && (cnt[rs2_i] != '0);

  // Entry 0 never sees an event (writers need rd!=0, kills of x0 are ignored), so it stays zero.
  always_comb begin
    err = 1'b0;
    v   = '0;
    s   = '0;
    dec = '0;
    for (int r = 0; r < 32; r++) begin
      v   = {2'b00, cnt[r]} + (SB_W+2)'(iss_valid_i && is_wr(iss_opcode_i, iss_rd_i) && iss_rd_i == 5'(r));
      dec = (SB_W+2)'(w_en_o && w_rd_o == 5'(r)) + (SB_W+2)'(kill_valid_i && kill_rd_i != 5'd0 && kill_rd_i == 5'(r));
      s   = v - dec;
      cnt_nxt[r] = v < dec ? '0 : s > MAX ? SB_W'(MAX) : SB_W'(s);
      err = err | (v < dec) | (v >= dec && s > MAX);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_valid        <= 1'b0;
      W_opcode_o     <= '0;
      W_rd_o         <= '0;
      W_valE_o       <= '0;
      W_valM_o       <= '0;
      W_default_pc_o <= '0;
      instret_o      <= '0;
      sb_err_o       <= 1'b0;
      cnt            <= '{default: '0};
    end else begin
      if (!stall_i) begin
        w_valid        <= M_valid_i;
        W_opcode_o     <= M_valid_i ? M_opcode_i : 7'd0;
        W_rd_o         <= M_rd_i;
        W_valE_o       <= M_valE_i;
        W_valM_o       <= m_valM_i;
        W_default_pc_o <= M_default_pc_i;
      end
      if (retire) instret_o <= instret_o + CNT_W'(1);
      cnt      <= cnt_nxt;
      sb_err_o <= sb_err_o | err;
    end
  end
endmodule

// File: tb/tb_wb_retire_ctrl.sv
// tb_wb_retire_ctrl: directed self-checking bench for wb_retire_ctrl.
module tb_wb_retire_ctrl;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_IMM  = 7'b0010011;

  logic        clk = 1'b0, rst;
  logic        M_valid, stall, iss_valid, kill_valid;
  logic [6:0]  M_opcode, iss_opcode;
  logic [4:0]  M_rd, iss_rd, kill_rd, rs1, rs2;
  logic [31:0] M_valE, m_valM, M_default_pc;
  logic [6:0]  W_opcode;
  logic [4:0]  W_rd, w_rd;
  logic [31:0] W_valE, W_valM, W_default_pc, w_data;
  logic        w_en, pend_rs1, pend_rs2, sb_err;
  logic [63:0] instret;
  int tests = 0, fails = 0;

  wb_retire_ctrl #(.SB_W(2), .CNT_W(64)) dut (
    .clk_i(clk), .rst_i(rst), .M_valid_i(M_valid), .M_opcode_i(M_opcode), .M_rd_i(M_rd),
    .M_valE_i(M_valE), .m_valM_i(m_valM), .M_default_pc_i(M_default_pc), .stall_i(stall),
    .iss_valid_i(iss_valid), .iss_opcode_i(iss_opcode), .iss_rd_i(iss_rd),
    .kill_valid_i(kill_valid), .kill_rd_i(kill_rd), .rs1_i(rs1), .rs2_i(rs2),
    .W_opcode_o(W_opcode), .W_rd_o(W_rd), .W_valE_o(W_valE), .W_valM_o(W_valM),
    .W_default_pc_o(W_default_pc), .w_en_o(w_en), .w_rd_o(w_rd), .w_data_o(w_data),
    .pend_rs1_o(pend_rs1), .pend_rs2_o(pend_rs2), .sb_err_o(sb_err), .instret_o(instret)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear();
    {M_valid, stall, iss_valid, kill_valid} = '0;
    {M_opcode, iss_opcode, M_rd, iss_rd, kill_rd} = '0;
    {M_valE, m_valM, M_default_pc} = '0;
  endtask

  task automatic issue(input logic [6:0] op, input logic [4:0] rd);
    iss_valid = 1'b1; iss_opcode = op; iss_rd = rd;
    step();
    iss_valid = 1'b0;
  endtask

  task automatic feed(input logic [6:0] op, input logic [4:0] rd, input logic [31:0] e, input logic [31:0] m, input logic [31:0] pc);
    M_valid = 1'b1; M_opcode = op; M_rd = rd; M_valE = e; m_valM = m; M_default_pc = pc;
    step();
    M_valid = 1'b0;
  endtask

  initial begin
    clear();
    rs1 = 5'd5; rs2 = 5'd0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_wop", 64'(W_opcode), 64'd0);
    chk("rst_wen", 64'(w_en), 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_pend", 64'(pend_rs1), 64'd0);
    chk("rst_err", 64'(sb_err), 64'd0);
    // basic ALU writer
    issue(OP_IMM, 5'd5);
    chk("imm_pend_set", 64'(pend_rs1), 64'd1);
    feed(OP_IMM, 5'd5, 32'h1234, 32'h9999, 32'h8);
    chk("imm_wen", 64'(w_en), 64'd1);
    chk("imm_wrd", 64'(w_rd), 64'd5);
    chk("imm_wdata", 64'(w_data), 64'h1234);
    chk("imm_pend_retiring", 64'(pend_rs1), 64'd1);
    chk("imm_instret_pre", instret, 64'd0);
    step();
    chk("imm_pend_clr", 64'(pend_rs1), 64'd0);
    chk("imm_instret", instret, 64'd1);
    chk("bubble_wen", 64'(w_en), 64'd0);
    // load and jal data selection
    issue(OP_LOAD, 5'd7);
    issue(OP_JAL, 5'd1);
    feed(OP_LOAD, 5'd7, 32'h1111, 32'hDEADBEEF, 32'h100);
    chk("ld_wdata", 64'(w_data), 64'hDEADBEEF);
    chk("ld_wen", 64'(w_en), 64'd1);
    feed(OP_JAL, 5'd1, 32'h55, 32'h66, 32'h104);
    chk("jal_wdata", 64'(w_data), 64'h104);
    chk("jal_wrd", 64'(w_rd), 64'd1);
    step();
    rs1 = 5'd7; rs2 = 5'd1;
    #1;
    chk("ldjal_instret", instret, 64'd3);
    chk("ldjal_pend1", 64'(pend_rs1), 64'd0);
    chk("ldjal_pend2", 64'(pend_rs2), 64'd0);
    chk("ldjal_err", 64'(sb_err), 64'd0);
    // stall holding a writer in W
    rs1 = 5'd3;
    issue(OP_R, 5'd3);
    feed(OP_R, 5'd3, 32'hAB, 32'h0, 32'h0);
    stall = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("stall_wen", 64'(w_en), 64'd0);
      chk("stall_instret", instret, 64'd3);
      chk("stall_pend", 64'(pend_rs1), 64'd1);
      step();
    end
    stall = 1'b0;
    #1;
    chk("rel_wen", 64'(w_en), 64'd1);
    chk("rel_wdata", 64'(w_data), 64'hAB);
    step();
    chk("rel_instret", instret, 64'd4);
    chk("rel_pend", 64'(pend_rs1), 64'd0);
    chk("rel_wen_once", 64'(w_en), 64'd0);
    step();
    chk("rel_instret_once", instret, 64'd4);
    chk("rel_err", 64'(sb_err), 64'd0);
    // saturation at 3 in-flight writers
    rs2 = 5'd9;
    issue(OP_R, 5'd9); issue(OP_R, 5'd9); issue(OP_R, 5'd9);
    chk("sat3_err", 64'(sb_err), 64'd0);
    chk("sat3_pend", 64'(pend_rs2), 64'd1);
    issue(OP_R, 5'd9);
    chk("sat4_err", 64'(sb_err), 64'd1);
    kill_valid = 1'b1; kill_rd = 5'd9;
    step(); step();
    kill_valid = 1'b0;
    chk("kill2_pend", 64'(pend_rs2), 64'd1);
    feed(OP_R, 5'd9, 32'h0, 32'h0, 32'h0);
    step();
    chk("sat_drain_pend", 64'(pend_rs2), 64'd0);
    chk("sat_err_sticky", 64'(sb_err), 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_err", 64'(sb_err), 64'd0);
    chk("rst2_instret", instret, 64'd0);
    // simultaneous inc/dec on rd=4 plus a kill of x0
    rs1 = 5'd4; rs2 = 5'd0;
    issue(OP_R, 5'd4);
    feed(OP_R, 5'd4, 32'h4, 32'h0, 32'h0);
    chk("sim_wen", 64'(w_en), 64'd1);
    iss_valid = 1'b1; iss_opcode = OP_R; iss_rd = 5'd4;
    kill_valid = 1'b1; kill_rd = 5'd0;
    step();
    iss_valid = 1'b0; kill_valid = 1'b0;
    chk("sim_pend", 64'(pend_rs1), 64'd1);
    chk("sim_err", 64'(sb_err), 64'd0);
    feed(OP_R, 5'd4, 32'h4, 32'h0, 32'h0);
    step();
    chk("sim_drain_pend", 64'(pend_rs1), 64'd0);
    chk("sim_drain_err", 64'(sb_err), 64'd0);
    chk("sim_instret", instret, 64'd2);
    // writer to x0
    rs1 = 5'd0;
    issue(OP_IMM, 5'd0);
    chk("x0_pend", 64'(pend_rs1), 64'd0);
    feed(OP_IMM, 5'd0, 32'h77, 32'h0, 32'h0);
    chk("x0_wen", 64'(w_en), 64'd0);
    step();
    chk("x0_instret", instret, 64'd3);
    chk("x0_err", 64'(sb_err), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
